// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite encodings: transfer types, sizes, burst/protection constants
// and response codes.
package ahblite_pkg;

    localparam logic [1:0] HTRANS_IDLE    = 2'b00;
    localparam logic [1:0] HTRANS_BUSY    = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ  = 2'b10;
    localparam logic [1:0] HTRANS_SEQ     = 2'b11;

    localparam logic [2:0] HSIZE_BYTE     = 3'b000;
    localparam logic [2:0] HSIZE_HALF     = 3'b001;
    localparam logic [2:0] HSIZE_WORD     = 3'b010;

    localparam logic [2:0] HBURST_SINGLE  = 3'b000;
    localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

    localparam logic       HRESP_OKAY     = 1'b0;
    localparam logic       HRESP_ERROR    = 1'b1;

endpackage

// File: rtl/ahblite_master_port.sv
// Single-outstanding-per-phase AHB-Lite master: a command register feeds the
// address phase, a second register tracks the data phase, responses in order.
module ahblite_master_port
    import ahblite_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETN,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_size,
    input  logic [DATA_W-1:0] cmd_wdata,

    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,

    output logic [ADDR_W-1:0] HADDR,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [1:0]        HTRANS,
    output logic [2:0]        HBURST,
    output logic [3:0]        HPROT,
    output logic              HMASTLOCK,
    output logic [DATA_W-1:0] HWDATA,

    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);

    logic              ap_valid;
    logic              ap_write;
    logic [ADDR_W-1:0] ap_addr;
    logic [2:0]        ap_size;
    logic [DATA_W-1:0] ap_wdata;

    logic              dp_valid;
    logic              dp_write;
    logic [DATA_W-1:0] dp_wdata;

    logic              err_hold;
    logic              cmd_accept;
    logic              addr_done;
    logic              data_done;

    // err_hold marks the second ERROR cycle, where the pending address must idle
    assign addr_done  = ap_valid && !err_hold && HREADY;
    assign data_done  = dp_valid && HREADY;
    assign cmd_ready  = !ap_valid || (HREADY && !err_hold);
    assign cmd_accept = cmd_valid && cmd_ready;

    assign HTRANS    = (ap_valid && !err_hold) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR     = ap_addr;
    assign HWRITE    = ap_write;
    assign HSIZE     = ap_size;
    assign HWDATA    = dp_valid ? dp_wdata : '0;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_DATA_PRIV;
    assign HMASTLOCK = 1'b0;

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            ap_valid <= 1'b0;
            ap_write <= 1'b0;
            ap_addr  <= '0;
            ap_size  <= '0;
            ap_wdata <= '0;
        end else if (cmd_accept) begin
            ap_valid <= 1'b1;
            ap_write <= cmd_write;
            ap_addr  <= cmd_addr;
            ap_size  <= cmd_size;
            ap_wdata <= cmd_wdata;
        end else if (addr_done) begin
            ap_valid <= 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_wdata <= '0;
        end else if (addr_done) begin
            dp_valid <= 1'b1;
            dp_write <= ap_write;
            dp_wdata <= ap_wdata;
        end else if (data_done) begin
            dp_valid <= 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            err_hold <= 1'b0;
        end else if (dp_valid && (HRESP == HRESP_ERROR) && !HREADY) begin
            err_hold <= 1'b1;
        end else if (HREADY) begin
            err_hold <= 1'b0;
        end
    end

    // Read data is only forwarded for successful reads
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= data_done;
            rsp_err   <= data_done && (HRESP == HRESP_ERROR);
            rsp_rdata <= (data_done && !dp_write && (HRESP == HRESP_OKAY)) ? HRDATA : '0;
        end
    end

endmodule

// File: tb/tb_ahblite_master_port.sv
// Bench for ahblite_master_port: transaction-level scoreboard checked every
// cycle plus directed scenarios with literal expectations.
module tb_ahblite_master_port;
    import ahblite_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESETN;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [2:0]  cmd_size;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic        HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;
    logic [1:0]  HTRANS;
    logic [3:0]  HPROT;

    always #5 HCLK = ~HCLK;

    ahblite_master_port #(.ADDR_W(32), .DATA_W(32)) dut (
        .HCLK(HCLK), .HRESETN(HRESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HTRANS(HTRANS),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    int n_tot  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge HCLK);
        #2;
    endtask

    // Transaction-level model: accepted commands wait in order, each address
    // phase must present the oldest one, each data phase produces one response.
    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } cmd_t;

    cmd_t        pend[$];
    cmd_t        dp_cmd;
    bit          dp_have = 0;
    bit          exp_rsp = 0;
    logic        exp_err;
    logic [31:0] exp_rdata;
    bit          prev_err1 = 0;
    int          outstanding = 0;

    always @(negedge HCLK) begin
        if (!HRESETN) begin
            pend.delete();
            dp_have = 0; exp_rsp = 0; prev_err1 = 0; outstanding = 0;
            chk("sb_rst_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
            chk("sb_rst_rsp_valid", 32'(rsp_valid), 0);
            chk("sb_rst_cmd_ready", 32'(cmd_ready), 1);
        end else begin
            chk("sb_const", {21'd0, HBURST, HPROT, HMASTLOCK, 3'd0}, {21'd0, 3'b000, 4'b0011, 1'b0, 3'd0});
            chk("sb_htrans_legal", 32'(HTRANS == HTRANS_IDLE || HTRANS == HTRANS_NONSEQ), 1);
            chk("sb_rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
            if (exp_rsp) begin
                chk("sb_rsp_err", 32'(rsp_err), 32'(exp_err));
                chk("sb_rsp_rdata", rsp_rdata, exp_rdata);
                outstanding--;
            end
            exp_rsp = 0;
            if (prev_err1) chk("sb_idle_err2", 32'(HTRANS), 32'(HTRANS_IDLE));
            prev_err1 = 0;
            if (dp_have) begin
                if (dp_cmd.write) chk("sb_hwdata", HWDATA, dp_cmd.wdata);
                if (HREADY) begin
                    exp_rsp   = 1;
                    exp_err   = HRESP;
                    exp_rdata = (!dp_cmd.write && !HRESP) ? HRDATA : 32'd0;
                    dp_have   = 0;
                end else if (HRESP) begin
                    prev_err1 = 1;
                end
            end
            if (HTRANS == HTRANS_NONSEQ) begin
                if (pend.size() == 0) begin
                    chk("sb_spurious_nonseq", 32'(pend.size()), 1);
                end else begin
                    chk("sb_haddr", HADDR, pend[0].addr);
                    chk("sb_hctl", {28'd0, HWRITE, HSIZE}, {28'd0, pend[0].write, pend[0].size});
                    if (HREADY) begin
                        dp_cmd  = pend.pop_front();
                        dp_have = 1;
                    end
                end
            end
            if (cmd_valid && cmd_ready) begin
                pend.push_back('{cmd_write, cmd_addr, cmd_size, cmd_wdata});
                outstanding++;
            end
        end
    end

    task automatic set_cmd(input logic w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_size = s; cmd_wdata = d;
    endtask

    task automatic send(input logic w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        bit done = 0;
        set_cmd(w, a, s, d);
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge HCLK);
            if (cmd_ready) done = 1;
            tick();
        end
        cmd_valid = 0;
        if (!done) begin
            n_tot++;
            $display("FAIL send_timeout: actual not accepted required accepted addr %0h", a);
        end
    endtask

    localparam int NSTREAM = 8;
    logic [31:0] s_addr [NSTREAM] = '{32'h500, 32'h504, 32'h508, 32'h50C, 32'h510, 32'h514, 32'h518, 32'h51C};
    logic        s_wr   [NSTREAM] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0]  s_sz   [NSTREAM] = '{3'd2, 3'd1, 3'd0, 3'd2, 3'd1, 3'd2, 3'd0, 3'd2};
    logic [7:0]  hready_pat = 8'b1011_0111;

    initial begin
        HRESETN = 0; HREADY = 1; HRESP = 0; HRDATA = 0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_size = 0; cmd_wdata = 0;
        #1;
        chk("reset_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
        chk("reset_haddr", HADDR, 0);
        chk("reset_hwdata", HWDATA, 0);
        chk("reset_ctl", {27'd0, HWRITE, HSIZE, rsp_err}, 0);
        chk("reset_rsp", {rsp_rdata[30:0], rsp_valid}, 0);
        chk("reset_cmd_ready", 32'(cmd_ready), 1);
        repeat (3) @(posedge HCLK);

        // Read, zero wait; accepted in the first cycle after reset release
        #2; HRESETN = 1; HRDATA = 32'hDEADBEEF;
        set_cmd(0, 32'h10, 3'd2, 32'd0);
        @(negedge HCLK); chk("r036_ready_c0", 32'(cmd_ready), 1);
        chk("r036_idle_c0", 32'(HTRANS), 32'(HTRANS_IDLE));
        tick(); cmd_valid = 0;
        @(negedge HCLK); chk("r036_nonseq_c1", 32'(HTRANS), 32'(HTRANS_NONSEQ));
        chk("r036_haddr_c1", HADDR, 32'h10);
        tick(); @(negedge HCLK); chk("r036_idle_c2", 32'(HTRANS), 32'(HTRANS_IDLE));
        chk("r036_norsp_c2", 32'(rsp_valid), 0);
        tick(); @(negedge HCLK); chk("r036_rsp_c3", 32'(rsp_valid), 1);
        chk("r036_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("r036_err", 32'(rsp_err), 0);
        tick(); @(negedge HCLK); chk("r036_rsp_c4", 32'(rsp_valid), 0);

        // Back-to-back writes
        tick(); set_cmd(1, 32'h100, 3'd2, 32'h11);
        tick(); set_cmd(1, 32'h104, 3'd2, 32'h22);
        @(negedge HCLK); chk("r037_nonseq1", {HADDR[15:0], 14'd0, HTRANS}, {16'h100, 14'd0, HTRANS_NONSEQ});
        chk("r037_ready1", 32'(cmd_ready), 1);
        tick(); cmd_valid = 0;
        @(negedge HCLK); chk("r037_nonseq2", {HADDR[15:0], 14'd0, HTRANS}, {16'h104, 14'd0, HTRANS_NONSEQ});
        chk("r037_hwdata1", HWDATA, 32'h11);
        tick(); @(negedge HCLK); chk("r037_hwdata2", HWDATA, 32'h22);
        chk("r037_rsp1", {rsp_rdata, rsp_valid} == 33'h1 ? 32'd1 : 32'd0, 1);
        tick(); @(negedge HCLK); chk("r037_rsp2", 32'(rsp_valid), 1);
        tick(); @(negedge HCLK); chk("r037_rsp_end", 32'(rsp_valid), 0);

        // Read with three wait states
        tick(); HRDATA = 32'h12345678; set_cmd(0, 32'h10, 3'd2, 32'h5A5A);
        tick(); cmd_valid = 0;
        @(negedge HCLK); chk("r038_nonseq", 32'(HTRANS), 32'(HTRANS_NONSEQ));
        for (int i = 0; i < 3; i++) begin
            tick(); HREADY = 0;
            @(negedge HCLK);
            chk("r038_haddr_wait", HADDR, 32'h10);
            chk("r038_hwdata_wait", HWDATA, 32'h5A5A);
            chk("r038_norsp_wait", 32'(rsp_valid), 0);
        end
        tick(); HREADY = 1;
        @(negedge HCLK); chk("r038_hwdata_last", HWDATA, 32'h5A5A);
        chk("r038_norsp_c5", 32'(rsp_valid), 0);
        tick(); @(negedge HCLK); chk("r038_rsp_c6", 32'(rsp_valid), 1);
        chk("r038_rdata", rsp_rdata, 32'h12345678);

        // Two-cycle ERROR on a write with a read pipelined behind it
        tick(); set_cmd(1, 32'h200, 3'd2, 32'h33);
        tick(); set_cmd(0, 32'h204, 3'd2, 32'h0);
        @(negedge HCLK); chk("r039_nonseq_w", HADDR, 32'h200);
        tick(); cmd_valid = 0; HREADY = 0; HRESP = 1;
        @(negedge HCLK); chk("r039_nonseq_r", {HADDR[15:0], 14'd0, HTRANS}, {16'h204, 14'd0, HTRANS_NONSEQ});
        tick(); HREADY = 1; HRESP = 1;
        @(negedge HCLK); chk("r039_idle_err2", 32'(HTRANS), 32'(HTRANS_IDLE));
        chk("r039_haddr_held", HADDR, 32'h204);
        chk("r039_ready_err2", 32'(cmd_ready), 0);
        tick(); HRESP = 0;
        @(negedge HCLK); chk("r039_rsp_err", {30'd0, rsp_valid, rsp_err}, 32'h3);
        chk("r039_rsp_rdata0", rsp_rdata, 0);
        chk("r039_reissue", {HADDR[15:0], 13'd0, HWRITE, HTRANS}, {16'h204, 13'd0, 1'b0, HTRANS_NONSEQ});
        tick(); HRDATA = 32'hCAFEF00D;
        tick(); @(negedge HCLK); chk("r039_rsp_read", {30'd0, rsp_valid, rsp_err}, 32'h2);
        chk("r039_rdata", rsp_rdata, 32'hCAFEF00D);

        // Reset during a data-phase wait state
        tick(); set_cmd(0, 32'h300, 3'd2, 32'h0);
        tick(); cmd_valid = 0;
        tick(); HREADY = 0;
        tick();
        #1; HRESETN = 0;
        #1; chk("r040_idle", 32'(HTRANS), 32'(HTRANS_IDLE));
        chk("r040_haddr", HADDR, 0);
        chk("r040_ready", 32'(cmd_ready), 1);
        @(posedge HCLK); #2; HRESETN = 1; HREADY = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK); chk("r040_norsp", 32'(rsp_valid), 0);
            tick();
        end
        HRDATA = 32'h0000_4040; set_cmd(0, 32'h10, 3'd2, 32'h0);
        tick(); cmd_valid = 0;
        tick(); tick(); @(negedge HCLK); chk("r040_new_rsp", 32'(rsp_valid), 1);
        chk("r040_new_rdata", rsp_rdata, 32'h4040);

        // ERROR with HREADY high and no first cycle: no IDLE gap afterwards
        tick(); set_cmd(0, 32'h400, 3'd2, 32'h0);
        tick(); set_cmd(0, 32'h404, 3'd2, 32'h0);
        @(negedge HCLK); chk("r041_ready", 32'(cmd_ready), 1);
        tick(); cmd_valid = 0; HRESP = 1; HRDATA = 32'h7777_7777;
        @(negedge HCLK); chk("r041_nonseq", {HADDR[15:0], 14'd0, HTRANS}, {16'h404, 14'd0, HTRANS_NONSEQ});
        tick(); HRESP = 0; HRDATA = 32'h0BADF00D;
        @(negedge HCLK); chk("r041_rsp_err", {30'd0, rsp_valid, rsp_err}, 32'h3);
        chk("r041_rdata0", rsp_rdata, 0);
        tick(); @(negedge HCLK); chk("r041_rsp2", {30'd0, rsp_valid, rsp_err}, 32'h2);
        chk("r041_rdata2", rsp_rdata, 32'h0BADF00D);

        // Mixed stream under a repeating wait-state pattern
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    tick();
                    HREADY = hready_pat[i % 8];
                    HRDATA = 32'hA000_0000 + 32'(i);
                end
            end
            begin
                for (int i = 0; i < NSTREAM; i++)
                    send(s_wr[i], s_addr[i], s_sz[i], 32'h100 + 32'(i));
            end
        join
        HREADY = 1;
        repeat (6) tick();
        @(negedge HCLK);
        chk("end_outstanding", 32'(outstanding), 0);
        chk("end_pending", 32'(pend.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1);
    end

endmodule

// File: doc/ahblite_master_port.md
AHBLITE_MASTER_PORT -- requirements
Module: ahblite_master_port

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 Parameter DATA_W, default 32, data width (32 only in this release).
REQ-003 HCLK  in  1  clock; all logic on rising edge.
REQ-004 HRESETN  in  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-007 cmd_write  in  1  1 = write, 0 = read.
REQ-008 cmd_addr  in  ADDR_W  transfer address.
REQ-009 cmd_size  in  3  HSIZE encoding; 0, 1 or 2 only.
REQ-010 cmd_wdata  in  DATA_W  write data.
REQ-011 rsp_valid  out  1  one-cycle pulse per completed command; no backpressure.
REQ-012 rsp_rdata  out  DATA_W  read data; 0 for writes.
REQ-013 rsp_err  out  1  slave returned ERROR.
REQ-014 HADDR, HWRITE, HSIZE  out  ADDR_W/1/3  AHB-Lite address-phase signals.
REQ-015 HTRANS  out  2  IDLE (00) or NONSEQ (10) only.
REQ-016 HBURST=000, HPROT=0011, HMASTLOCK=0  out  3/4/1  constant.
REQ-017 HWDATA  out  DATA_W  data-phase write data.
REQ-018 HRDATA, HREADY, HRESP  in  DATA_W/1/1  AHB-Lite slave response; HRESP 1 = ERROR.

Function
REQ-019 Address-phase register (ap) holds at most one command; data-phase register (dp) holds at most one command.
REQ-020 cmd_ready = !ap_valid || (HREADY && !err_hold); an accepted command loads ap at the next edge.
REQ-021 HTRANS = NONSEQ when ap_valid && !err_hold, else IDLE; HADDR/HWRITE/HSIZE always driven from ap.
REQ-022 The address phase completes on an edge with HTRANS=NONSEQ && HREADY=1: ap moves to dp, and a command accepted in the same cycle loads ap. Back-to-back pipelining is therefore zero-bubble.
REQ-023 HWDATA = dp_wdata whenever dp_valid; it is held stable through wait states.
REQ-024 The data phase completes on an edge with dp_valid && HREADY=1. At the next cycle: rsp_valid=1, rsp_err=HRESP, and rsp_rdata=HRDATA for reads (0 for writes, 0 when rsp_err=1).
REQ-025 Latency, zero wait states: acceptance at cycle 0; NONSEQ in cycle 1; data phase in cycle 2; rsp_valid in cycle 3.
REQ-026 err_hold is set at an edge where dp_valid && HRESP=1 && HREADY=0 (first ERROR cycle). It clears at the next edge where HREADY=1.
REQ-027 While err_hold=1 (second ERROR cycle), a pending ap command is not issued: HTRANS=IDLE and ap is retained. It is re-issued as NONSEQ with identical HADDR/HWRITE/HSIZE the cycle after the error completes. No command is dropped.
REQ-028 HRESP=1 with HREADY=1 and no preceding first ERROR cycle (protocol violation) is still reported as rsp_err=1; err_hold is not set.
REQ-029 Responses are returned strictly in acceptance order.
REQ-030 Extended wait states (HREADY=0, HRESP=0) of any length stall both ap and dp without loss.

Reset
REQ-031 Asynchronous assertion of HRESETN clears ap_valid, dp_valid, err_hold and rsp_valid. Outputs then read HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, rsp_rdata=0, rsp_err=0, cmd_ready=1.
REQ-032 Reset mid-transfer discards all in-flight commands; no rsp_valid is generated for them after reset.
REQ-033 Release of reset is synchronous to HCLK; the first acceptance is possible in the first cycle after release.

Structure
REQ-034 HTRANS/HSIZE/HBURST/HPROT encodings and the HRESP OKAY/ERROR constants are defined in the shared package ahblite_pkg.
REQ-035 The block is a single module with no sub-modules; the ap/dp registers are inline.

Verification
REQ-036 Read 0x0000_0010, zero wait, HRDATA=0xDEADBEEF -> NONSEQ at cycle 1, rsp_valid at cycle 3, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-037 Writes 0x100 data 0x11, then 0x104 data 0x22, back-to-back -> consecutive NONSEQ cycles; HWDATA=0x11 then 0x22; two rsp_valid pulses in consecutive cycles.
REQ-038 Read with HREADY held low for 3 cycles -> HADDR/HWDATA stable throughout; rsp_valid 3 cycles later than REQ-036.
REQ-039 Write 0x200 gets a two-cycle ERROR while a read of 0x204 is pipelined -> HTRANS=IDLE in the second ERROR cycle; rsp_err=1 for 0x200; 0x204 re-issued as NONSEQ and completes with rsp_err=0.
REQ-040 HRESETN asserted during a data-phase wait state -> HTRANS=IDLE immediately; no rsp_valid after release; a new command is accepted normally.
REQ-041 HRESP=1 with HREADY=1 and no first ERROR cycle -> rsp_err=1, next pipelined command proceeds without an IDLE gap.
